// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and external memory handshakes around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic                if_req;
    logic [XLEN-1:0]     if_adr;
    logic                if_flush;
    logic                if_gnt;
    logic                if_rvalid;
    logic [XLEN-1:0]     if_rdata;

    logic                ls_req;
    logic                ls_we;
    logic [XLEN/8-1:0]   ls_be;
    logic [XLEN-1:0]     ls_adr;
    logic [XLEN-1:0]     ls_wdata;
    logic                ls_gnt;
    logic                ls_rvalid;
    logic [XLEN-1:0]     ls_rdata;

    logic                mem_req;
    logic                mem_we;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_adr;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [XLEN-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_adr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_adr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_adr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_adr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_adr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_adr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (fetch vs load/store) with one outstanding transaction,
// LS priority bounded by a starvation streak counter, and fetch-flush response dropping.
module mem_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic           clk_i,
    input logic           rst_ni,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned BeW     = XLEN / 8;
    localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e               state_q, state_d;
    logic [StreakW-1:0]   streak_q, streak_d;
    logic                 drop_q, drop_d;
    logic                 owner_ls_q, owner_ls_d;
    logic                 we_q, we_d;
    logic [BeW-1:0]       be_q, be_d;
    logic [XLEN-1:0]      adr_q, adr_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;

    logic resp, arb, if_elig, if_win, ls_win;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        drop_d     = drop_q;
        owner_ls_d = owner_ls_q;
        we_d       = we_q;
        be_d       = be_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;

        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.ls_gnt    = 1'b0;
        bus.ls_rvalid = 1'b0;
        bus.ls_rdata  = '0;
        bus.mem_req   = (state_q == StIssue);
        bus.mem_we    = we_q;
        bus.mem_be    = be_q;
        bus.mem_adr   = adr_q;
        bus.mem_wdata = wdata_q;

        // No grants or forwarded responses while reset is asserted; nothing would be captured.
        resp    = rst_ni && (state_q == StWait) && bus.mem_rvalid;
        arb     = rst_ni && ((state_q == StIdle) || resp);
        if_elig = bus.if_req && !bus.if_flush;
        if_win  = arb && if_elig && (!bus.ls_req || (streak_q == StreakW'(MAX_STREAK)));
        ls_win  = arb && bus.ls_req && !if_win;

        bus.if_gnt = if_win;
        bus.ls_gnt = ls_win;

        if (resp) begin
            if (owner_ls_q) begin
                bus.ls_rvalid = 1'b1;
                bus.ls_rdata  = bus.mem_rdata;
            end else if (!drop_q && !bus.if_flush) begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_rdata;
            end
        end

        if (resp) begin
            drop_d = 1'b0;
        end else if ((state_q != StIdle) && !owner_ls_q && bus.if_flush) begin
            drop_d = 1'b1;
        end

        if (if_win) begin
            owner_ls_d = 1'b0;
            we_d       = 1'b0;
            be_d       = '1;
            adr_d      = bus.if_adr;
            wdata_d    = '0;
            streak_d   = '0;
        end else if (ls_win) begin
            owner_ls_d = 1'b1;
            we_d       = bus.ls_we;
            be_d       = bus.ls_be;
            adr_d      = bus.ls_adr;
            wdata_d    = bus.ls_wdata;
            if (if_elig && (streak_q != StreakW'(MAX_STREAK))) begin
                streak_d = streak_q + StreakW'(1);
            end
        end

        unique case (state_q)
            StIdle:  if (if_win || ls_win) state_d = StIssue;
            StIssue: if (bus.mem_gnt) state_d = StWait;
            StWait:  if (bus.mem_rvalid) state_d = (if_win || ls_win) ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            streak_q   <= '0;
            drop_q     <= 1'b0;
            owner_ls_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            drop_q     <= drop_d;
            owner_ls_q <= owner_ls_d;
            we_q       <= we_d;
            be_q       <= be_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned MaxStreak = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(
        .XLEN       (XLEN),
        .MAX_STREAK (MaxStreak)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model: at most one transaction held, either waiting for the bus or on it.
    bit          m_have, m_on_bus, m_owner_ls, m_drop, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_adr, m_wdata;
    int          m_streak;

    bit          e_if_win, e_ls_win, e_if_ok, e_resp, e_if_rvalid, e_ls_rvalid, e_mem_req;
    logic [31:0] e_if_rdata, e_ls_rdata;

    logic        last_if_gnt, last_ls_gnt, last_if_rvalid, last_ls_rvalid, last_mem_req;
    logic [31:0] last_if_rdata, last_mem_adr;

    bit          if_pend, ls_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_on_bus = 0; m_owner_ls = 0; m_drop = 0; m_we = 0;
        m_be = '0; m_adr = '0; m_wdata = '0; m_streak = 0;
    endtask

    task automatic model_eval();
        bit free;
        e_resp      = rst_ni && m_have && m_on_bus && bus.mem_rvalid;
        free        = rst_ni && (!m_have || e_resp);
        e_if_ok     = bus.if_req && !bus.if_flush;
        e_if_win    = free && e_if_ok && (!bus.ls_req || m_streak == MaxStreak);
        e_ls_win    = free && bus.ls_req && !e_if_win;
        e_ls_rvalid = e_resp && m_owner_ls;
        e_if_rvalid = e_resp && !m_owner_ls && !m_drop && !bus.if_flush;
        e_if_rdata  = e_if_rvalid ? bus.mem_rdata : 32'h0;
        e_ls_rdata  = e_ls_rvalid ? bus.mem_rdata : 32'h0;
        e_mem_req   = m_have && !m_on_bus;
    endtask

    task automatic model_update();
        if (!rst_ni) begin
            model_reset();
            return;
        end
        if (m_have && !m_owner_ls && bus.if_flush) m_drop = 1;
        if (m_have && !m_on_bus && bus.mem_gnt) m_on_bus = 1;
        if (e_resp) begin
            m_have = 0;
            m_drop = 0;
        end
        if (e_if_win || e_ls_win) begin
            m_have     = 1;
            m_on_bus   = 0;
            m_owner_ls = e_ls_win;
        end
        if (e_if_win) begin
            m_we = 0; m_be = 4'hF; m_adr = bus.if_adr; m_wdata = 32'h0;
            m_streak = 0;
        end else if (e_ls_win) begin
            m_we = bus.ls_we; m_be = bus.ls_be; m_adr = bus.ls_adr; m_wdata = bus.ls_wdata;
            if (e_if_ok && m_streak < MaxStreak) m_streak++;
        end
    endtask

    // One clock: check outputs 1ns after inputs settle, advance the model at the edge.
    task automatic step();
        #1;
        model_eval();
        last_if_gnt    = bus.if_gnt;
        last_ls_gnt    = bus.ls_gnt;
        last_if_rvalid = bus.if_rvalid;
        last_ls_rvalid = bus.ls_rvalid;
        last_if_rdata  = bus.if_rdata;
        last_mem_req   = bus.mem_req;
        last_mem_adr   = bus.mem_adr;
        if (chk_en) begin
            chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, e_if_win});
            chk("ls_gnt", {31'b0, bus.ls_gnt}, {31'b0, e_ls_win});
            chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, e_if_rvalid});
            chk("ls_rvalid", {31'b0, bus.ls_rvalid}, {31'b0, e_ls_rvalid});
            chk("if_rdata", bus.if_rdata, e_if_rdata);
            chk("ls_rdata", bus.ls_rdata, e_ls_rdata);
            chk("mem_req", {31'b0, bus.mem_req}, {31'b0, e_mem_req});
            if (e_mem_req) begin
                chk("mem_adr", bus.mem_adr, m_adr);
                chk("mem_we", {31'b0, bus.mem_we}, {31'b0, m_we});
                chk("mem_be", {28'b0, bus.mem_be}, {28'b0, m_be});
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
        end
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_adr = '0; bus.if_flush = 0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = '0; bus.ls_adr = '0; bus.ls_wdata = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    task automatic rand_drive();
        rst_ni = ($urandom_range(0, 199) != 0);
        if (!if_pend && $urandom_range(0, 1) == 1) begin
            if_pend    = 1;
            bus.if_adr = $urandom;
        end
        if (!ls_pend && $urandom_range(0, 1) == 1) begin
            ls_pend      = 1;
            bus.ls_we    = 1'($urandom_range(0, 1));
            bus.ls_be    = 4'($urandom_range(0, 15));
            bus.ls_adr   = $urandom;
            bus.ls_wdata = $urandom;
        end
        bus.if_req     = if_pend;
        bus.ls_req     = ls_pend;
        bus.if_flush   = ($urandom_range(0, 9) == 0);
        bus.mem_gnt    = (m_have && !m_on_bus) ? ($urandom_range(0, 2) != 0)
                                                 : ($urandom_range(0, 7) == 0);
        bus.mem_rvalid = (m_have && m_on_bus) ? ($urandom_range(0, 1) == 1)
                                                : ($urandom_range(0, 7) == 0);
        bus.mem_rdata  = $urandom;
    endtask

    initial begin
        logic [9:0] order;
        int         n_gnt;

        idle_inputs();
        model_reset();
        if_pend = 0;
        ls_pend = 0;

        rst_ni = 0;
        step();
        chk_en = 1;
        step();
        chk("rst_mem_adr", bus.mem_adr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
        rst_ni = 1;

        // Single fetch with immediate bus grant
        bus.if_req = 1; bus.if_adr = 32'h100;
        step();
        chk("sf_if_gnt", {31'b0, last_if_gnt}, 32'h1);
        bus.if_req = 0; bus.mem_gnt = 1;
        step();
        chk("sf_mem_req", {31'b0, last_mem_req}, 32'h1);
        chk("sf_mem_adr", last_mem_adr, 32'h100);
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h13;
        step();
        chk("sf_if_rvalid", {31'b0, last_if_rvalid}, 32'h1);
        chk("sf_if_rdata", last_if_rdata, 32'h13);
        idle_inputs();
        step();

        // Store with a stalled bus grant
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_be = 4'h3; bus.ls_adr = 32'h2000;
        bus.ls_wdata = 32'hCAFE;
        step();
        chk("st_ls_gnt", {31'b0, last_ls_gnt}, 32'h1);
        bus.ls_req = 0; bus.ls_adr = 32'h0; bus.ls_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_gnt = (i == 3);
            step();
            chk("st_mem_req_held", {31'b0, last_mem_req}, 32'h1);
            chk("st_mem_adr_held", last_mem_adr, 32'h2000);
        end
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
        step();
        chk("st_ls_rvalid", {31'b0, last_ls_rvalid}, 32'h1);
        chk("st_if_rvalid", {31'b0, last_if_rvalid}, 32'h0);
        idle_inputs();
        step();

        // Continuous contention: LS wins MaxStreak times, then IF once
        bus.if_req = 1; bus.if_adr = 32'h400; bus.ls_req = 1; bus.ls_adr = 32'h8000;
        bus.mem_gnt = 1; bus.mem_rvalid = 1;
        order = '0;
        n_gnt = 0;
        for (int c = 0; c < 40 && n_gnt < 10; c++) begin
            step();
            if (last_if_gnt || last_ls_gnt) begin
                order[n_gnt] = last_if_gnt;
                n_gnt++;
            end
        end
        chk("ct_grants", n_gnt, 10);
        chk("ct_order", {22'b0, order}, {22'b0, 10'b10_0001_0000});
        bus.if_req = 0; bus.ls_req = 0;
        step();
        step();
        idle_inputs();
        step();

        // Flush while the fetch waits for its response
        bus.if_req = 1; bus.if_adr = 32'h200;
        step();
        bus.if_req = 0; bus.mem_gnt = 1;
        step();
        bus.mem_gnt = 0; bus.if_flush = 1;
        step();
        bus.if_flush = 0;
        step();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD;
        step();
        chk("fl_dropped", {31'b0, last_if_rvalid}, 32'h0);
        idle_inputs();
        bus.if_req = 1; bus.if_adr = 32'h300;
        step();
        bus.if_req = 0; bus.mem_gnt = 1;
        step();
        bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBEEF;
        step();
        chk("fl_next_rvalid", {31'b0, last_if_rvalid}, 32'h1);
        chk("fl_next_rdata", last_if_rdata, 32'hBEEF);
        idle_inputs();
        step();

        // Back-to-back: LS granted in the IF response cycle
        bus.if_req = 1; bus.if_adr = 32'h500;
        step();
        bus.if_req = 0; bus.mem_gnt = 1;
        step();
        bus.mem_gnt = 0; bus.ls_req = 1; bus.ls_adr = 32'h5000;
        step();
        chk("bb_ls_wait", {31'b0, last_ls_gnt}, 32'h0);
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
        step();
        chk("bb_if_rvalid", {31'b0, last_if_rvalid}, 32'h1);
        chk("bb_ls_gnt", {31'b0, last_ls_gnt}, 32'h1);
        bus.ls_req = 0; bus.mem_rvalid = 0;
        step();
        chk("bb_mem_req", {31'b0, last_mem_req}, 32'h1);
        chk("bb_mem_adr", last_mem_adr, 32'h5000);
        bus.mem_gnt = 1;
        step();
        bus.mem_gnt = 0; bus.mem_rvalid = 1;
        step();
        idle_inputs();
        step();

        // Reset during WAIT, late response afterwards
        bus.if_req = 1; bus.if_adr = 32'h600;
        step();
        bus.if_req = 0; bus.mem_gnt = 1;
        step();
        bus.mem_gnt = 0; rst_ni = 0;
        step();
        rst_ni = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h99;
        step();
        chk("rw_if_rvalid", {31'b0, last_if_rvalid}, 32'h0);
        chk("rw_mem_req", {31'b0, last_mem_req}, 32'h0);
        chk("rw_ls_rvalid", {31'b0, last_ls_rvalid}, 32'h0);
        idle_inputs();
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_drive();
            step();
            if (e_if_win) if_pend = 0;
            if (e_ls_win) ls_pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
